// File: rtl/input_stream_buffer.sv
// Double-banked input buffer: DMA fills one bank while the compute side streams the other.
// Optional INBUF_STALL_STATS_EN adds a saturating count of back-pressured output cycles.
module input_stream_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4096,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dma_wr_en,
  input  logic [ADDR_WIDTH-1:0] dma_wr_addr,
  input  logic [DATA_WIDTH-1:0] dma_wr_data,
  input  logic                  dma_commit,
  output logic                  fill_ready,
  output logic                  data_ready,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  reuse,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [31:0]           stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic                  r_fillBank;
  logic                  r_drainBank;
  logic [1:0]            r_full;
  logic [1:0]            w_fullNext;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] r_mem [0:1][0:DEPTH-1];

  logic [ADDR_WIDTH:0]   r_len;
  logic                  r_reuse;
  logic [ADDR_WIDTH:0]   r_issueCnt;
  logic [ADDR_WIDTH-1:0] r_rdAddr;

  logic                  r_rdValid;
  logic                  r_rdLast;
  logic [DATA_WIDTH-1:0] r_rdData;

  logic [DATA_WIDTH-1:0] r_fifoData [0:1];
  logic                  r_fifoLast [0:1];
  logic                  r_wrPtr;
  logic                  r_rdPtr;
  logic [1:0]            r_count;

  logic                  w_fillReady;
  logic                  w_dataReady;
  logic                  w_startAcc;
  logic                  w_commitOk;
  logic                  w_release;
  logic                  w_pop;
  logic                  w_lastPop;
  logic [2:0]            w_credit;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_issueAddr;
  logic                  w_issueLast;

  function automatic logic [ADDR_WIDTH-1:0] wrapInc(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(DEPTH - 1)) return '0;
    return a + 1'b1;
  endfunction

  assign w_fillReady = !r_full[r_fillBank];
  assign w_dataReady = r_full[r_drainBank];
  assign w_startAcc  = (r_state == IDLE) && start && w_dataReady;
  assign w_commitOk  = dma_commit && w_fillReady;
  assign w_release   = (r_state == FINISH) && !r_reuse;
  assign w_pop       = (r_count != 2'd0) && out_ready;
  assign w_lastPop   = w_pop && r_fifoLast[r_rdPtr];
  // Credit counts what the FIFO will hold once this cycle's pop and in-flight read settle
  assign w_credit    = 3'(r_count) + 3'(r_rdValid) - 3'(w_pop);

  assign fill_ready = w_fillReady;
  assign data_ready = w_dataReady;
  assign out_valid  = (r_count != 2'd0);
  assign out_data   = r_fifoData[r_rdPtr];
  assign out_last   = out_valid && r_fifoLast[r_rdPtr];
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == FINISH);
  assign overflow   = r_overflow;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Zero-length streams skip straight to the completion state
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_startAcc) w_nextState = (length == '0) ? FINISH : STREAM;
      end
      STREAM: begin
        if (w_lastPop) w_nextState = FINISH;
      end
      FINISH:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The first read goes out in the start cycle itself so data is visible two cycles later
  always_comb begin
    w_issue     = 1'b0;
    w_issueAddr = r_rdAddr;
    w_issueLast = 1'b0;
    if (r_state == IDLE) begin
      w_issue     = w_startAcc && (length != '0);
      w_issueAddr = base_addr;
      w_issueLast = (length == (ADDR_WIDTH + 1)'(1));
    end else if (r_state == STREAM) begin
      w_issue     = (r_issueCnt < r_len) && (w_credit < 3'd2);
      w_issueLast = (r_issueCnt == r_len - 1'b1);
    end
  end

  // Commit and release are merged so both take effect in the same cycle
  always_comb begin
    w_fullNext = r_full;
    if (w_commitOk) w_fullNext[r_fillBank]  = 1'b1;
    if (w_release)  w_fullNext[r_drainBank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full      <= 2'b00;
      r_fillBank  <= 1'b0;
      r_drainBank <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_full <= w_fullNext;
      if (w_commitOk) r_fillBank <= !r_fillBank;
      if (w_release)  r_drainBank <= !r_drainBank;
      if (dma_commit && !w_fillReady) r_overflow <= 1'b1;
    end
  end

  // Stream parameters are captured once at start; the read pointer wraps at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_reuse    <= 1'b0;
      r_issueCnt <= '0;
      r_rdAddr   <= '0;
    end else if (w_startAcc) begin
      r_len      <= length;
      r_reuse    <= reuse;
      r_issueCnt <= w_issue ? (ADDR_WIDTH + 1)'(1) : '0;
      r_rdAddr   <= w_issue ? wrapInc(base_addr) : base_addr;
    end else if (w_issue) begin
      r_issueCnt <= r_issueCnt + 1'b1;
      r_rdAddr   <= wrapInc(r_rdAddr);
    end
  end

  // Bank storage is not reset; a full fill bank never coincides with the drain bank being written
  always_ff @(posedge clk) begin
    if (dma_wr_en && w_fillReady) r_mem[r_fillBank][dma_wr_addr] <= dma_wr_data;
    if (w_issue) r_rdData <= r_mem[r_drainBank][w_issueAddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdValid <= 1'b0;
      r_rdLast  <= 1'b0;
    end else begin
      r_rdValid <= w_issue;
      r_rdLast  <= w_issue && w_issueLast;
    end
  end

  // Two-entry skid FIFO; the credit check guarantees a push never finds it full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifoData[0] <= '0;
      r_fifoData[1] <= '0;
      r_fifoLast[0] <= 1'b0;
      r_fifoLast[1] <= 1'b0;
      r_wrPtr       <= 1'b0;
      r_rdPtr       <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      if (r_rdValid) begin
        r_fifoData[r_wrPtr] <= r_rdData;
        r_fifoLast[r_wrPtr] <= r_rdLast;
        r_wrPtr             <= !r_wrPtr;
      end
      if (w_pop) r_rdPtr <= !r_rdPtr;
      r_count <= r_count + 2'(r_rdValid) - 2'(w_pop);
    end
  end

`ifdef INBUF_STALL_STATS_EN
  logic [31:0] r_stallCnt;

  // Saturating count of cycles where a valid beat waited on the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stallCnt <= '0;
    else if (out_valid && !out_ready && (r_stallCnt != 32'hFFFF_FFFF))
      r_stallCnt <= r_stallCnt + 1'b1;
  end

  assign stall_cnt = r_stallCnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_input_stream_buffer.sv
// Self-checking bench for input_stream_buffer: bank/queue model plus directed scenarios.
// Stall-count expectation follows INBUF_STALL_STATS_EN.
module tb_input_stream_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef INBUF_STALL_STATS_EN
  localparam int EXP_STALL = 2;
`else
  localparam int EXP_STALL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dma_wr_en;
  logic [AW-1:0] dma_wr_addr;
  logic [DW-1:0] dma_wr_data;
  logic          dma_commit;
  logic          fill_ready;
  logic          data_ready;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          reuse;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [31:0]   stall_cnt;

  input_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr), .dma_wr_data(dma_wr_data),
    .dma_commit(dma_commit), .fill_ready(fill_ready), .data_ready(data_ready),
    .start(start), .base_addr(base_addr), .length(length), .reuse(reuse),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mMem [2][DEPTH];
  bit            mFull [2];
  bit            mFill, mDrain, mOverflow, mReuse;
  logic [DW:0]   expQ [$];

  logic [DW-1:0] seenData [32];
  bit            seenLast [32];
  int            seenCnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock of DMA-side stimulus, mirrored into the bank model
  task automatic applyStimulus(input bit wrEn, input int addr, input logic [DW-1:0] data, input bit commit);
    dma_wr_en   = wrEn;
    dma_wr_addr = AW'(addr);
    dma_wr_data = data;
    dma_commit  = commit;
    if (wrEn && !mFull[mFill]) mMem[mFill][addr] = data;
    if (commit) begin
      if (!mFull[mFill]) begin
        mFull[mFill] = 1'b1;
        mFill = !mFill;
      end else mOverflow = 1'b1;
    end
    @(posedge clk);
    #1;
    dma_wr_en  = 1'b0;
    dma_commit = 1'b0;
  endtask

  task automatic issueStart(input int base, input int len, input bit re, output bit acc);
    acc = mFull[mDrain];
    if (acc) begin
      mReuse = re;
      for (int k = 0; k < len; k++) begin
        bit lastK = (k == len - 1);
        expQ.push_back({lastK, mMem[mDrain][(base + k) % DEPTH]});
      end
    end
    start     = 1'b1;
    base_addr = AW'(base);
    length    = (AW + 1)'(len);
    reuse     = re;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    bit seen = 1'b0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", seen, 1);
    checkOutput("beats_outstanding", expQ.size(), 0);
    if (!mReuse) begin
      mFull[mDrain] = 1'b0;
      mDrain = !mDrain;
    end
    @(posedge clk);
    #1;
  endtask

  logic [DW:0]   e;
  bit            prevStall = 1'b0;
  logic [DW-1:0] prevData;

  // Every-cycle comparison of the output stream against the expected-beat queue
  always @(negedge clk) begin
    if (!rst_n) prevStall = 1'b0;
    else begin
      if (prevStall) begin
        checkOutput("stall_valid_hold", out_valid, 1);
        checkOutput("stall_data_hold", out_data, prevData);
      end
      if (out_valid && out_ready && expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("beat_data", out_data, e[DW-1:0]);
        checkOutput("beat_last", out_last, e[DW]);
        if (seenCnt < 32) begin
          seenData[seenCnt] = out_data;
          seenLast[seenCnt] = out_last;
        end
        seenCnt++;
      end else if (expQ.size() == 0) checkOutput("idle_valid", out_valid, 0);
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
    end
  end

  initial begin
    bit acc;
    int cyc;
    int lat;
    bit anyBusy;
    logic [DW-1:0] lit37 [4];
    lit37 = '{32'h10E, 32'h10F, 32'h100, 32'h101};

    rst_n = 1'b0; dma_wr_en = 1'b0; dma_wr_addr = '0; dma_wr_data = '0; dma_commit = 1'b0;
    start = 1'b0; base_addr = '0; length = '0; reuse = 1'b0; out_ready = 1'b1;
    mFull = '{1'b0, 1'b0}; mFill = 1'b0; mDrain = 1'b0; mOverflow = 1'b0; mReuse = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_out_last", out_last, 0);
    @(posedge clk); @(posedge clk);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_fill_ready", fill_ready, 1);
    checkOutput("rst_data_ready", data_ready, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    #1 rst_n = 1'b1;

    // Basic 8-beat stream from bank 0
    for (int a = 0; a < 8; a++) applyStimulus(1, a, DW'(a), 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t36_data_ready", data_ready, 1);
    seenCnt = 0;
    issueStart(0, 8, 0, acc);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      lat = i;
      if (out_valid) break;
    end
    checkOutput("t36_first_latency", lat, 2);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checkOutput("t36_consecutive", out_valid, 1);
    end
    waitDone(cyc);
    checkOutput("t36_done_delay", cyc, 1);
    checkOutput("t36_done_pulse", done, 0);
    checkOutput("t36_data_ready_after", data_ready, 0);
    checkOutput("t36_beat_count", seenCnt, 8);
    for (int k = 0; k < 8; k++) checkOutput("t36_literal", seenData[k], k);
    checkOutput("t36_last7", seenLast[7], 1);
    checkOutput("t36_last6", seenLast[6], 0);

    // Wrap-around read from bank 1
    for (int a = 0; a < DEPTH; a++) applyStimulus(1, a, 32'h100 + DW'(a), 0);
    applyStimulus(0, 0, 0, 1);
    seenCnt = 0;
    issueStart(DEPTH - 2, 4, 0, acc);
    waitDone(cyc);
    for (int k = 0; k < 4; k++) checkOutput("t37_wrap_literal", seenData[k], lit37[k]);
    checkOutput("t37_last", seenLast[3], 1);

    // Back-pressure: out_ready 1,0,0,1
    for (int a = 0; a < 8; a++) applyStimulus(1, a, 32'h200 + DW'(a), 0);
    applyStimulus(0, 0, 0, 1);
    seenCnt = 0;
    issueStart(0, 8, 0, acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    waitDone(cyc);
    checkOutput("t38_beat_count", seenCnt, 8);
    for (int k = 0; k < 8; k++) checkOutput("t38_literal", seenData[k], 32'h200 + k);
    checkOutput("t38_stall_cnt", stall_cnt, EXP_STALL);

    // Overflow, dropped writes, reuse
    for (int a = 0; a < 4; a++) applyStimulus(1, a, 32'h300 + DW'(a), 0);
    applyStimulus(0, 0, 0, 1);
    for (int a = 0; a < 4; a++) applyStimulus(1, a, 32'h400 + DW'(a), 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t39_fill_ready_full", fill_ready, 0);
    checkOutput("t39_overflow_before", overflow, 0);
    for (int a = 0; a < 4; a++) applyStimulus(1, a, 32'h500 + DW'(a), 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t39_overflow", overflow, mOverflow);
    checkOutput("t39_overflow_literal", overflow, 1);
    checkOutput("t39_fill_ready", fill_ready, 0);
    for (int r = 0; r < 2; r++) begin
      seenCnt = 0;
      issueStart(0, 4, 1, acc);
      waitDone(cyc);
      for (int k = 0; k < 4; k++) checkOutput("t39_reuse_literal", seenData[k], 32'h300 + k);
      checkOutput("t39_reuse_keeps", data_ready, 1);
    end
    issueStart(0, 4, 0, acc);
    waitDone(cyc);
    checkOutput("t39_release_fill_ready", fill_ready, 1);

    // Refill bank 1 while bank 0 streams; commit and release land on the same edge
    seenCnt = 0;
    fork
      begin
        bit a2;
        int c2;
        issueStart(0, 4, 0, a2);
        waitDone(c2);
      end
      begin
        for (int a = 0; a < 6; a++) applyStimulus(1, a, 32'h600 + DW'(a), 0);
        applyStimulus(0, 0, 0, 1);
      end
    join
    for (int k = 0; k < 4; k++) checkOutput("t31_literal", seenData[k], 32'h400 + k);
    checkOutput("t30_data_ready", data_ready, 1);
    checkOutput("t30_fill_ready", fill_ready, 1);

    // Reset during the third beat of eight
    seenCnt = 0;
    issueStart(0, 8, 0, acc);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (seenCnt >= 3) break;
    end
    checkOutput("t40_beats_before_reset", seenCnt, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("t40_rst_out_valid", out_valid, 0);
    checkOutput("t40_rst_busy", busy, 0);
    checkOutput("t40_rst_done", done, 0);
    expQ.delete();
    mFull = '{1'b0, 1'b0}; mFill = 1'b0; mDrain = 1'b0; mOverflow = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("t40_fill_ready", fill_ready, 1);
    checkOutput("t40_data_ready", data_ready, 0);
    checkOutput("t40_overflow", overflow, 0);
    checkOutput("t40_stall_cnt", stall_cnt, 0);
    checkOutput("t40_out_data", out_data, 0);
    issueStart(0, 4, 0, acc);
    checkOutput("t40_model_rejects", acc, 0);
    anyBusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      anyBusy |= busy | done;
    end
    checkOutput("t40_ignored_start", anyBusy, 0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 1);
    seenCnt = 0;
    issueStart(0, 0, 0, acc);
    waitDone(cyc);
    checkOutput("t40_len0_done_delay", cyc, 1);
    checkOutput("t40_len0_no_beats", seenCnt, 0);
    checkOutput("t40_len0_released", data_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
